// File: rtl/vga_board_capture.sv
// vga_board_capture
// Receiving end of the board VGA output. Rebuilds pixel timing from the sync
// edges alone, samples the centre pixel of each of the 8x8 board cells, and
// publishes the rebuilt 64-bit board once per clean frame.
module vga_board_capture #(
    parameter int H_TOTAL         = 800,
    parameter int H_SYNC_START    = 656,
    parameter int V_TOTAL         = 525,
    parameter int V_SYNC_START    = 490,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int BOARD_X0        = 120,
    parameter int BOARD_Y0        = 40,
    parameter int CELL_SIZE       = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  r_in,
    input  logic [1:0]  g_in,
    input  logic [1:0]  b_in,
    output logic [63:0] board_out,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        locked,
    output logic        color_error,
    output logic [7:0]  frame_count
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_RELOAD = HW'(H_SYNC_START + 1);
    localparam logic [HW-1:0] X_FIRST  = HW'(BOARD_X0 + CELL_SIZE / 2);
    localparam logic [HW-1:0] X_STEP   = HW'(CELL_SIZE);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] Y_FIRST  = VW'(BOARD_Y0 + CELL_SIZE / 2);
    localparam logic [VW-1:0] Y_STEP   = VW'(CELL_SIZE);

    localparam logic [5:0] PIX_ALIVE  = 6'b10_00_10;
    localparam logic [5:0] PIX_DEAD   = 6'b11_10_11;
    localparam logic [6:0] FULL_FRAME = 7'd64;

    // Sync edge detection and timing reconstruction
    logic          hs, vs, hs_q, vs_q;
    logic          hs_edge, vs_edge, h_wrap, v_wrap;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_locked_q, h_locked_d;
    logic          v_locked_q, v_locked_d;

    // Sample-point generation (incrementing compare registers)
    logic [HW-1:0] x_cmp_q, x_cmp_d;
    logic [2:0]    x_idx_q, x_idx_d;
    logic          x_done_q, x_done_d;
    logic [VW-1:0] y_cmp_q, y_cmp_d;
    logic [2:0]    y_idx_q, y_idx_d;
    logic          y_done_q, y_done_d;
    logic          x_hit, y_hit, sample_hit;

    // Capture and publish state
    logic [5:0]    pix;
    logic [5:0]    cell_idx;
    logic          publish;
    logic [63:0]   shadow_q, shadow_d;
    logic [6:0]    sample_cnt_q, sample_cnt_d;
    logic          bad_q, bad_d;
    logic [63:0]   board_q, board_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_changed_q, frame_changed_d;
    logic          color_error_q, color_error_d;
    logic [7:0]    frame_count_q, frame_count_d;

    assign hs      = hsync_in ^ SYNC_ACTIVE_LOW;
    assign vs      = vsync_in ^ SYNC_ACTIVE_LOW;
    assign hs_edge = hs & ~hs_q;
    assign vs_edge = vs & ~vs_q;

    // hcnt wraps only when no hs edge reloads it this cycle.
    assign h_wrap  = ~hs_edge & (hcnt_q == H_LAST);
    assign v_wrap  = h_wrap & (vcnt_q == V_LAST);

    assign x_hit      = ~x_done_q & (hcnt_q == x_cmp_q);
    assign y_hit      = ~y_done_q & (vcnt_q == y_cmp_q);
    assign sample_hit = x_hit & y_hit;
    assign pix        = {r_in, g_in, b_in};
    assign cell_idx   = {y_idx_q, x_idx_q};

    // A publish needs the vs edge to land where the predicted count says it
    // should, horizontal lock held, no error in the frame and every cell seen.
    assign publish = vs_edge & (vcnt_q == V_SYNC) & h_locked_q & ~bad_q
                   & (sample_cnt_q == FULL_FRAME);

    assign board_out     = board_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign locked        = h_locked_q & v_locked_q;
    assign color_error   = color_error_q;
    assign frame_count   = frame_count_q;

    // Next-state logic: counters, lock tracking, sampling, decode and publish.
    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves one unassigned and infers a latch.
        hcnt_d          = hcnt_q;
        vcnt_d          = vcnt_q;
        h_locked_d      = h_locked_q;
        v_locked_d      = v_locked_q;
        x_cmp_d         = x_cmp_q;
        x_idx_d         = x_idx_q;
        x_done_d        = x_done_q;
        y_cmp_d         = y_cmp_q;
        y_idx_d         = y_idx_q;
        y_done_d        = y_done_q;
        shadow_d        = shadow_q;
        sample_cnt_d    = sample_cnt_q;
        bad_d           = bad_q;
        board_d         = board_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = frame_changed_q;
        color_error_d   = color_error_q;
        frame_count_d   = frame_count_q;

        // Horizontal timing: an hs edge means the pins carry hpos H_SYNC_START.
        if (hs_edge) begin
            hcnt_d     = H_RELOAD;
            h_locked_d = (hcnt_q == H_SYNC);
            if (hcnt_q != H_SYNC) begin
                bad_d = 1'b1;
            end
        end else if (h_wrap) begin
            hcnt_d = '0;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end

        // Vertical timing: the vs edge reload wins over the line increment.
        if (vs_edge) begin
            vcnt_d     = V_SYNC;
            v_locked_d = (vcnt_q == V_SYNC);
        end else if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        end

        // Column compare steps across the line and rearms at each line start.
        if (h_wrap) begin
            x_cmp_d  = X_FIRST;
            x_idx_d  = '0;
            x_done_d = 1'b0;
        end else if (x_hit) begin
            if (x_idx_q == 3'd7) begin
                x_done_d = 1'b1;
            end else begin
                x_idx_d = x_idx_q + 1'b1;
                x_cmp_d = x_cmp_q + X_STEP;
            end
        end

        // Row compare steps at the end of each sampled line, rearms per frame.
        if (vs_edge || v_wrap) begin
            y_cmp_d  = Y_FIRST;
            y_idx_d  = '0;
            y_done_d = 1'b0;
        end else if (h_wrap && y_hit) begin
            if (y_idx_q == 3'd7) begin
                y_done_d = 1'b1;
            end else begin
                y_idx_d = y_idx_q + 1'b1;
                y_cmp_d = y_cmp_q + Y_STEP;
            end
        end

        // Decode the centre pixel of the current cell.
        if (sample_hit) begin
            if (pix == PIX_ALIVE) begin
                shadow_d[cell_idx] = 1'b1;
                sample_cnt_d       = sample_cnt_q + 7'd1;
            end else if (pix == PIX_DEAD) begin
                shadow_d[cell_idx] = 1'b0;
                sample_cnt_d       = sample_cnt_q + 7'd1;
            end else begin
                color_error_d = 1'b1;
                bad_d         = 1'b1;
            end
        end

        if (publish) begin
            board_d         = shadow_q;
            frame_changed_d = (shadow_q != board_q);
            frame_valid_d   = 1'b1;
            frame_count_d   = frame_count_q + 8'd1;
        end

        // Every vs edge opens a fresh frame, published or not.
        if (vs_edge) begin
            bad_d         = 1'b0;
            sample_cnt_d  = '0;
            color_error_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q            <= 1'b0;
            vs_q            <= 1'b0;
            hcnt_q          <= '0;
            vcnt_q          <= '0;
            h_locked_q      <= 1'b0;
            v_locked_q      <= 1'b0;
            x_cmp_q         <= X_FIRST;
            x_idx_q         <= '0;
            x_done_q        <= 1'b0;
            y_cmp_q         <= Y_FIRST;
            y_idx_q         <= '0;
            y_done_q        <= 1'b0;
            // NOTE: the shadow board is cleared with everything else so no stale cell from before reset can reach a publish.
            shadow_q        <= '0;
            sample_cnt_q    <= '0;
            // The frame interrupted by reset is discarded, so the first vs edge only resyncs.
            bad_q           <= 1'b1;
            board_q         <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            color_error_q   <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            hs_q            <= hs;
            vs_q            <= vs;
            hcnt_q          <= hcnt_d;
            vcnt_q          <= vcnt_d;
            h_locked_q      <= h_locked_d;
            v_locked_q      <= v_locked_d;
            x_cmp_q         <= x_cmp_d;
            x_idx_q         <= x_idx_d;
            x_done_q        <= x_done_d;
            y_cmp_q         <= y_cmp_d;
            y_idx_q         <= y_idx_d;
            y_done_q        <= y_done_d;
            shadow_q        <= shadow_d;
            sample_cnt_q    <= sample_cnt_d;
            bad_q           <= bad_d;
            board_q         <= board_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            color_error_q   <= color_error_d;
            frame_count_q   <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_vga_board_capture.sv
// Testbench for vga_board_capture: a small-timing VGA renderer drives two
// instances (active-low and active-high sync) through directed scenarios.
module tb_vga_board_capture;

    localparam int H_TOTAL      = 48;
    localparam int H_SYNC_START = 40;
    localparam int V_TOTAL      = 40;
    localparam int V_SYNC_START = 37;
    localparam int BOARD_X0     = 4;
    localparam int BOARD_Y0     = 2;
    localparam int CELL_SIZE    = 4;

    localparam logic [63:0] UW      = 64'h50A8_8888_0609_0909;
    localparam logic [63:0] BLINK_A = 64'h0000_0000_3800_0000;
    localparam logic [63:0] BLINK_B = 64'h0000_1010_1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_lo, vsync_lo, hsync_hi, vsync_hi;
    logic [1:0]  r_in, g_in, b_in;

    logic [63:0] board_lo, board_hi;
    logic        frame_valid_lo, frame_valid_hi;
    logic        changed_lo, changed_hi;
    logic        locked_lo, locked_hi;
    logic        cerr_lo, cerr_hi;
    logic [7:0]  count_lo, count_hi;

    // Renderer state
    int          hpos, vpos;
    int          drv_h = -1, drv_v = -1, proc_h = -1, proc_v = -1;
    logic [63:0] board_m;
    bit          bad_pix_en;
    int          delay_line;
    int          valid_lo_n, valid_hi_n;
    int          total, bad;

    always #5 clk = ~clk;

    vga_board_capture #(
        .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START), .V_TOTAL(V_TOTAL),
        .V_SYNC_START(V_SYNC_START), .SYNC_ACTIVE_LOW(1'b1), .BOARD_X0(BOARD_X0),
        .BOARD_Y0(BOARD_Y0), .CELL_SIZE(CELL_SIZE)
    ) dut_lo (
        .clk(clk), .reset(reset), .hsync_in(hsync_lo), .vsync_in(vsync_lo),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .board_out(board_lo),
        .frame_valid(frame_valid_lo), .frame_changed(changed_lo), .locked(locked_lo),
        .color_error(cerr_lo), .frame_count(count_lo)
    );

    vga_board_capture #(
        .H_TOTAL(H_TOTAL), .H_SYNC_START(H_SYNC_START), .V_TOTAL(V_TOTAL),
        .V_SYNC_START(V_SYNC_START), .SYNC_ACTIVE_LOW(1'b0), .BOARD_X0(BOARD_X0),
        .BOARD_Y0(BOARD_Y0), .CELL_SIZE(CELL_SIZE)
    ) dut_hi (
        .clk(clk), .reset(reset), .hsync_in(hsync_hi), .vsync_in(vsync_hi),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .board_out(board_hi),
        .frame_valid(frame_valid_hi), .frame_changed(changed_hi), .locked(locked_hi),
        .color_error(cerr_hi), .frame_count(count_hi)
    );

    // One pixel per clock: observe outputs of the previous pixel, drive the next.
    task automatic step_pixel();
        logic [5:0] pix;
        bit hs_on, vs_on;
        int cx, cy;
        @(negedge clk);
        proc_h = drv_h;
        proc_v = drv_v;
        if (frame_valid_lo === 1'b1) valid_lo_n++;
        if (frame_valid_hi === 1'b1) valid_hi_n++;
        if (vpos == delay_line)
            hs_on = (hpos >= H_SYNC_START + 3) && (hpos < H_SYNC_START + 4);
        else
            hs_on = (hpos >= H_SYNC_START) && (hpos < H_SYNC_START + 4);
        vs_on = (vpos == V_SYNC_START) || (vpos == V_SYNC_START + 1);
        pix = 6'b00_00_00;
        if (hpos >= BOARD_X0 && hpos < BOARD_X0 + 8 * CELL_SIZE &&
            vpos >= BOARD_Y0 && vpos < BOARD_Y0 + 8 * CELL_SIZE) begin
            cx  = (hpos - BOARD_X0) / CELL_SIZE;
            cy  = (vpos - BOARD_Y0) / CELL_SIZE;
            pix = board_m[cy * 8 + cx] ? 6'b10_00_10 : 6'b11_10_11;
        end
        if (bad_pix_en && hpos == BOARD_X0 + CELL_SIZE / 2 && vpos == BOARD_Y0 + CELL_SIZE / 2)
            pix = 6'b01_01_01;
        {r_in, g_in, b_in} = pix;
        hsync_lo = ~hs_on;
        vsync_lo = ~vs_on;
        hsync_hi = hs_on;
        vsync_hi = vs_on;
        drv_h = hpos;
        drv_v = vpos;
        hpos++;
        if (hpos == H_TOTAL) begin
            hpos = 0;
            vpos++;
            if (vpos == V_TOTAL) vpos = 0;
        end
    endtask

    // Step until the DUT has processed pixel (h, v); bounded to one frame plus slack.
    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        do begin
            step_pixel();
            n++;
        end while (!(proc_h == h && proc_v == v) && n < H_TOTAL * V_TOTAL + 4);
        if (!(proc_h == h && proc_v == v)) begin
            total++; bad++;
            $display("FAIL run_until timeout: reached %0d,%0d wanted %0d,%0d", proc_h, proc_v, h, v);
        end
    endtask

    task automatic run_to_vs();
        valid_lo_n = 0;
        valid_hi_n = 0;
        run_until(0, V_SYNC_START);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hpos  = 5;
        vpos  = 20;
        repeat (3) step_pixel();
        reset = 1'b0;
        total++; if (board_lo !== 64'h0) begin bad++; $display("FAIL reset_board: got %h expected 0", board_lo); end
        total++; if (frame_valid_lo !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", frame_valid_lo); end
        total++; if (changed_lo !== 1'b0) begin bad++; $display("FAIL reset_changed: got %b expected 0", changed_lo); end
        total++; if (locked_lo !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b expected 0", locked_lo); end
        total++; if (cerr_lo !== 1'b0) begin bad++; $display("FAIL reset_cerr: got %b expected 0", cerr_lo); end
        total++; if (count_lo !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count_lo); end
    endtask

    task automatic test_lock_publish();
        board_m = UW;
        run_to_vs();
        total++; if (valid_lo_n !== 0) begin bad++; $display("FAIL first_vs_no_publish: got %0d pulses expected 0", valid_lo_n); end
        total++; if (locked_lo !== 1'b0) begin bad++; $display("FAIL first_vs_locked: got %b expected 0", locked_lo); end
        run_to_vs();
        total++; if (valid_lo_n !== 1) begin bad++; $display("FAIL second_vs_pulses: got %0d expected 1", valid_lo_n); end
        total++; if (frame_valid_lo !== 1'b1) begin bad++; $display("FAIL second_vs_valid: got %b expected 1", frame_valid_lo); end
        total++; if (board_lo !== UW) begin bad++; $display("FAIL uw_board: got %h expected %h", board_lo, UW); end
        total++; if (changed_lo !== 1'b1) begin bad++; $display("FAIL uw_changed: got %b expected 1", changed_lo); end
        total++; if (count_lo !== 8'd1) begin bad++; $display("FAIL uw_count: got %0d expected 1", count_lo); end
        total++; if (locked_lo !== 1'b1) begin bad++; $display("FAIL uw_locked: got %b expected 1", locked_lo); end
        run_to_vs();
        total++; if (valid_lo_n !== 1) begin bad++; $display("FAIL repeat_pulses: got %0d expected 1", valid_lo_n); end
        total++; if (changed_lo !== 1'b0) begin bad++; $display("FAIL repeat_changed: got %b expected 0", changed_lo); end
        total++; if (count_lo !== 8'd2) begin bad++; $display("FAIL repeat_count: got %0d expected 2", count_lo); end
        total++; if (count_hi !== 8'd2) begin bad++; $display("FAIL repeat_count_hi: got %0d expected 2", count_hi); end
    endtask

    task automatic test_color_error();
        bad_pix_en = 1'b1;
        run_until(BOARD_X0 + CELL_SIZE / 2 - 1, BOARD_Y0 + CELL_SIZE / 2);
        total++; if (cerr_lo !== 1'b0) begin bad++; $display("FAIL cerr_before: got %b expected 0", cerr_lo); end
        run_until(BOARD_X0 + CELL_SIZE / 2, BOARD_Y0 + CELL_SIZE / 2);
        total++; if (cerr_lo !== 1'b1) begin bad++; $display("FAIL cerr_set: got %b expected 1", cerr_lo); end
        valid_lo_n = 0;
        run_until(0, V_SYNC_START);
        bad_pix_en = 1'b0;
        total++; if (valid_lo_n !== 0) begin bad++; $display("FAIL cerr_no_publish: got %0d pulses expected 0", valid_lo_n); end
        total++; if (board_lo !== UW) begin bad++; $display("FAIL cerr_board_held: got %h expected %h", board_lo, UW); end
        total++; if (count_lo !== 8'd2) begin bad++; $display("FAIL cerr_count_held: got %0d expected 2", count_lo); end
        total++; if (cerr_lo !== 1'b0) begin bad++; $display("FAIL cerr_cleared_at_vs: got %b expected 0", cerr_lo); end
        run_to_vs();
        total++; if (valid_lo_n !== 1) begin bad++; $display("FAIL cerr_recover_pulses: got %0d expected 1", valid_lo_n); end
        total++; if (count_lo !== 8'd3) begin bad++; $display("FAIL cerr_recover_count: got %0d expected 3", count_lo); end
        total++; if (cerr_lo !== 1'b0) begin bad++; $display("FAIL cerr_recover_flag: got %b expected 0", cerr_lo); end
    endtask

    task automatic test_hsync_glitch();
        delay_line = 10;
        run_until(H_SYNC_START + 2, 10);
        total++; if (locked_lo !== 1'b1) begin bad++; $display("FAIL glitch_pre_locked: got %b expected 1", locked_lo); end
        run_until(H_SYNC_START + 3, 10);
        total++; if (locked_lo !== 1'b0) begin bad++; $display("FAIL glitch_unlocked: got %b expected 0", locked_lo); end
        run_until(H_SYNC_START, 12);
        delay_line = -1;
        total++; if (locked_lo !== 1'b1) begin bad++; $display("FAIL glitch_relocked: got %b expected 1", locked_lo); end
        valid_lo_n = 0;
        run_until(0, V_SYNC_START);
        total++; if (valid_lo_n !== 0) begin bad++; $display("FAIL glitch_no_publish: got %0d pulses expected 0", valid_lo_n); end
        total++; if (count_lo !== 8'd3) begin bad++; $display("FAIL glitch_count_held: got %0d expected 3", count_lo); end
        run_to_vs();
        total++; if (valid_lo_n !== 1) begin bad++; $display("FAIL glitch_recover_pulses: got %0d expected 1", valid_lo_n); end
        total++; if (count_lo !== 8'd4) begin bad++; $display("FAIL glitch_recover_count: got %0d expected 4", count_lo); end
    endtask

    task automatic test_reset_midframe();
        run_until(10, 20);
        reset = 1'b1;
        step_pixel();
        reset = 1'b0;
        total++; if (board_lo !== 64'h0) begin bad++; $display("FAIL mid_reset_board: got %h expected 0", board_lo); end
        total++; if (count_lo !== 8'd0) begin bad++; $display("FAIL mid_reset_count: got %0d expected 0", count_lo); end
        total++; if (locked_lo !== 1'b0) begin bad++; $display("FAIL mid_reset_locked: got %b expected 0", locked_lo); end
        total++; if (changed_lo !== 1'b0) begin bad++; $display("FAIL mid_reset_changed: got %b expected 0", changed_lo); end
        run_to_vs();
        total++; if (valid_lo_n !== 0) begin bad++; $display("FAIL mid_reset_first_vs: got %0d pulses expected 0", valid_lo_n); end
        run_to_vs();
        total++; if (valid_lo_n !== 1) begin bad++; $display("FAIL mid_reset_second_vs: got %0d pulses expected 1", valid_lo_n); end
        total++; if (board_lo !== UW) begin bad++; $display("FAIL mid_reset_board_after: got %h expected %h", board_lo, UW); end
        total++; if (count_lo !== 8'd1) begin bad++; $display("FAIL mid_reset_count_after: got %0d expected 1", count_lo); end
        total++; if (changed_lo !== 1'b1) begin bad++; $display("FAIL mid_reset_changed_after: got %b expected 1", changed_lo); end
    endtask

    task automatic test_active_high();
        board_m = 64'h0;
        run_to_vs();
        total++; if (valid_hi_n !== 1) begin bad++; $display("FAIL hi_pulses_1: got %0d expected 1", valid_hi_n); end
        total++; if (board_hi !== 64'h0) begin bad++; $display("FAIL hi_board_1: got %h expected 0", board_hi); end
        run_to_vs();
        total++; if (valid_hi_n !== 1) begin bad++; $display("FAIL hi_pulses_2: got %0d expected 1", valid_hi_n); end
        total++; if (board_hi !== 64'h0) begin bad++; $display("FAIL hi_board_2: got %h expected 0", board_hi); end
        total++; if (changed_hi !== 1'b0) begin bad++; $display("FAIL hi_changed_2: got %b expected 0", changed_hi); end
        total++; if (count_hi !== 8'd3) begin bad++; $display("FAIL hi_count: got %0d expected 3", count_hi); end
    endtask

    task automatic test_back_to_back();
        board_m = BLINK_A;
        run_to_vs();
        total++; if (board_lo !== BLINK_A) begin bad++; $display("FAIL blink_a1_board: got %h expected %h", board_lo, BLINK_A); end
        total++; if (changed_lo !== 1'b1) begin bad++; $display("FAIL blink_a1_changed: got %b expected 1", changed_lo); end
        board_m = BLINK_B;
        run_to_vs();
        total++; if (board_lo !== BLINK_B) begin bad++; $display("FAIL blink_b_board: got %h expected %h", board_lo, BLINK_B); end
        total++; if (changed_lo !== 1'b1) begin bad++; $display("FAIL blink_b_changed: got %b expected 1", changed_lo); end
        board_m = BLINK_A;
        run_to_vs();
        total++; if (board_lo !== BLINK_A) begin bad++; $display("FAIL blink_a2_board: got %h expected %h", board_lo, BLINK_A); end
        total++; if (changed_lo !== 1'b1) begin bad++; $display("FAIL blink_a2_changed: got %b expected 1", changed_lo); end
        total++; if (count_lo !== 8'd6) begin bad++; $display("FAIL blink_count: got %0d expected 6", count_lo); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        hsync_lo   = 1'b1;
        vsync_lo   = 1'b1;
        hsync_hi   = 1'b0;
        vsync_hi   = 1'b0;
        r_in       = 2'b00;
        g_in       = 2'b00;
        b_in       = 2'b00;
        board_m    = 64'h0;
        bad_pix_en = 1'b0;
        delay_line = -1;
        valid_lo_n = 0;
        valid_hi_n = 0;

        test_reset();
        test_lock_publish();
        test_color_error();
        test_hsync_glitch();
        test_reset_midframe();
        test_active_high();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
